// File: rtl/dual_spectrum_frame_buffer.sv
// Ping-pong spectrum frame store for two FFT channels, with per-frame peak tracking.
// Optional feature macro: SPEC_PEAK_DETECT_EN (peak trackers; outputs tie to 0 when undefined).

module dual_spectrum_frame_buffer_chan #(
    parameter int FFT_POINTS   = 8192,
    parameter int STORE_BINS   = 4096,
    parameter int ADDR_W       = 12,
    parameter int PEAK_MIN_BIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       wr_data,
    input  logic [12:0]       wr_addr,
    input  logic              wr_valid,
    input  logic              lock,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_q,
    output logic              frame_ready,
    output logic              ovr_inc,
    output logic [12:0]       peak_bin,
    output logic [15:0]       peak_mag
);

    localparam logic [12:0] LAST_BIN  = 13'(FFT_POINTS - 1);
    localparam logic [13:0] STORE_LIM = 14'(STORE_BINS);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t      state;
    logic        wr_bank;
    logic        in_frame;
    logic        frame_start;
    logic        frame_done;
    logic        in_store;
    logic        do_swap;

    logic [15:0] ram [0:(2**(ADDR_W+1))-1];

    assign frame_start = wr_valid && (wr_addr == 13'd0);
    assign frame_done  = wr_valid && in_frame && (wr_addr == LAST_BIN);
    assign in_store    = wr_valid && ({1'b0, wr_addr} < STORE_LIM);
    assign do_swap     = !lock && ((state == IDLE && frame_done) || state == PENDING);
    // A frame completing while one is already waiting discards the older one.
    assign ovr_inc     = (state == PENDING) && frame_done;

    always_ff @(posedge clk) begin
        if (in_store)
            ram[{wr_bank, wr_addr[ADDR_W-1:0]}] <= wr_data;
        if (rd_en)
            rd_q <= ram[{~wr_bank, rd_addr}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame <= 1'b0;
        end else if (frame_start) begin
            in_frame <= 1'b1;
        end else if (frame_done) begin
            in_frame <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_bank     <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            frame_ready <= do_swap;
            if (do_swap)
                wr_bank <= ~wr_bank;
            unique case (state)
                IDLE: begin
                    if (frame_done && lock)
                        state <= PENDING;
                end
                PENDING: begin
                    if (!lock)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPEC_PEAK_DETECT_EN
    localparam logic [13:0] PEAK_LO = 14'(PEAK_MIN_BIN);

    logic [12:0] trk_bin;
    logic [15:0] trk_mag;
    logic [12:0] done_bin;
    logic [15:0] done_mag;
    logic [12:0] base_bin;
    logic [15:0] base_mag;
    logic [12:0] nx_bin;
    logic [15:0] nx_mag;
    logic        in_window;
    logic        take;

    assign in_window = ({1'b0, wr_addr} >= PEAK_LO) && ({1'b0, wr_addr} < STORE_LIM);

    always_comb begin
        base_bin = frame_start ? 13'd0 : trk_bin;
        base_mag = frame_start ? 16'd0 : trk_mag;
        take     = wr_valid && (in_frame || frame_start) && in_window
                   && (wr_data > base_mag);
        nx_bin   = take ? wr_addr : base_bin;
        nx_mag   = take ? wr_data : base_mag;
    end

    // done_* holds the newest completed frame until it is swapped in.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_bin  <= 13'd0;
            trk_mag  <= 16'd0;
            done_bin <= 13'd0;
            done_mag <= 16'd0;
            peak_bin <= 13'd0;
            peak_mag <= 16'd0;
        end else begin
            trk_bin <= nx_bin;
            trk_mag <= nx_mag;
            if (frame_done) begin
                done_bin <= nx_bin;
                done_mag <= nx_mag;
            end
            if (do_swap) begin
                peak_bin <= frame_done ? nx_bin : done_bin;
                peak_mag <= frame_done ? nx_mag : done_mag;
            end
        end
    end
`else
    assign peak_bin = 13'd0;
    assign peak_mag = 16'd0;
`endif

endmodule

module dual_spectrum_frame_buffer #(
    parameter int FFT_POINTS   = 8192,
    parameter int STORE_BINS   = 4096,
    parameter int ADDR_W       = 12,
    parameter int PEAK_MIN_BIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ch1_wr_data,
    input  logic [12:0]       ch1_wr_addr,
    input  logic              ch1_wr_valid,
    input  logic [15:0]       ch2_wr_data,
    input  logic [12:0]       ch2_wr_addr,
    input  logic              ch2_wr_valid,
    input  logic [1:0]        rd_lock,
    input  logic              rd_en,
    input  logic              rd_ch,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [1:0]        frame_ready,
    output logic [15:0]       ovr_cnt,
    output logic [12:0]       ch1_peak_bin,
    output logic [15:0]       ch1_peak_mag,
    output logic [12:0]       ch2_peak_bin,
    output logic [15:0]       ch2_peak_mag
);

    logic [15:0] q1;
    logic [15:0] q2;
    logic        ovr1;
    logic        ovr2;
    logic        rd_v1;
    logic        rd_ch_q;
    logic [1:0]  ovr_add;
    logic [16:0] ovr_sum;

    dual_spectrum_frame_buffer_chan #(
        .FFT_POINTS  (FFT_POINTS),
        .STORE_BINS  (STORE_BINS),
        .ADDR_W      (ADDR_W),
        .PEAK_MIN_BIN(PEAK_MIN_BIN)
    ) u_ch1 (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (ch1_wr_data),
        .wr_addr    (ch1_wr_addr),
        .wr_valid   (ch1_wr_valid),
        .lock       (rd_lock[0]),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_q       (q1),
        .frame_ready(frame_ready[0]),
        .ovr_inc    (ovr1),
        .peak_bin   (ch1_peak_bin),
        .peak_mag   (ch1_peak_mag)
    );

    dual_spectrum_frame_buffer_chan #(
        .FFT_POINTS  (FFT_POINTS),
        .STORE_BINS  (STORE_BINS),
        .ADDR_W      (ADDR_W),
        .PEAK_MIN_BIN(PEAK_MIN_BIN)
    ) u_ch2 (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (ch2_wr_data),
        .wr_addr    (ch2_wr_addr),
        .wr_valid   (ch2_wr_valid),
        .lock       (rd_lock[1]),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_q       (q2),
        .frame_ready(frame_ready[1]),
        .ovr_inc    (ovr2),
        .peak_bin   (ch2_peak_bin),
        .peak_mag   (ch2_peak_mag)
    );

    assign ovr_add = {1'b0, ovr1} + {1'b0, ovr2};
    assign ovr_sum = {1'b0, ovr_cnt} + {15'd0, ovr_add};

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1    <= 1'b0;
            rd_ch_q  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 16'd0;
            ovr_cnt  <= 16'd0;
        end else begin
            rd_v1    <= rd_en;
            if (rd_en)
                rd_ch_q <= rd_ch;
            rd_valid <= rd_v1;
            if (rd_v1)
                rd_data <= rd_ch_q ? q2 : q1;
            ovr_cnt  <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
        end
    end

endmodule

// File: tb/tb_dual_spectrum_frame_buffer.sv
// Directed bench for dual_spectrum_frame_buffer.
// Build with +define+SPEC_PEAK_DETECT_EN to exercise the peak trackers.

module tb_dual_spectrum_frame_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ch1_wr_data;
    logic [12:0] ch1_wr_addr;
    logic        ch1_wr_valid;
    logic [15:0] ch2_wr_data;
    logic [12:0] ch2_wr_addr;
    logic        ch2_wr_valid;
    logic [1:0]  rd_lock;
    logic        rd_en;
    logic        rd_ch;
    logic [11:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [1:0]  frame_ready;
    logic [15:0] ovr_cnt;
    logic [12:0] ch1_peak_bin;
    logic [15:0] ch1_peak_mag;
    logic [12:0] ch2_peak_bin;
    logic [15:0] ch2_peak_mag;

    int n_checks = 0;
    int n_errors = 0;
    int fr0 = 0;
    int fr1 = 0;
    int frb = 0;
    int base0;

    always #5 clk = ~clk;

    dual_spectrum_frame_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .ch1_wr_data (ch1_wr_data),
        .ch1_wr_addr (ch1_wr_addr),
        .ch1_wr_valid(ch1_wr_valid),
        .ch2_wr_data (ch2_wr_data),
        .ch2_wr_addr (ch2_wr_addr),
        .ch2_wr_valid(ch2_wr_valid),
        .rd_lock     (rd_lock),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .frame_ready (frame_ready),
        .ovr_cnt     (ovr_cnt),
        .ch1_peak_bin(ch1_peak_bin),
        .ch1_peak_mag(ch1_peak_mag),
        .ch2_peak_bin(ch2_peak_bin),
        .ch2_peak_mag(ch2_peak_mag)
    );

    always @(negedge clk) begin
        if (frame_ready[0]) fr0++;
        if (frame_ready[1]) fr1++;
        if (frame_ready == 2'b11) frb++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind 0: ch1=addr, ch2=~addr; kind 1: both=k; kind 2: peak pattern on ch1
    task automatic run_frame(input logic [1:0] chm, input int lo, input int hi,
                             input int kind, input logic [15:0] k);
        logic [15:0] d;
        for (int a = lo; a <= hi; a++) begin
            ch1_wr_valid = chm[0];
            ch2_wr_valid = chm[1];
            ch1_wr_addr  = 13'(a);
            ch2_wr_addr  = 13'(a);
            if (kind == 0) begin
                ch1_wr_data = 16'(a);
                ch2_wr_data = ~16'(a);
            end else if (kind == 1) begin
                ch1_wr_data = k;
                ch2_wr_data = k;
            end else begin
                if (a == 3) d = 16'd5000;
                else if (a == 700 || a == 701) d = 16'd900;
                else d = 16'd10;
                ch1_wr_data = d;
                ch2_wr_data = d;
            end
            tick(1);
        end
        ch1_wr_valid = 1'b0;
        ch2_wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic ch, input int a, input logic [15:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_ch   = ch;
        rd_addr = 12'(a);
        tick(1);
        rd_en = 1'b0;
        check({tag, "_early"}, rd_valid, 1'b0);
        tick(1);
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_data"}, rd_data, exp);
        tick(1);
        check({tag, "_idle"}, rd_valid, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fr"}, frame_ready, 2'b00);
        check({tag, "_ovr"}, ovr_cnt, 16'd0);
        check({tag, "_rdv"}, rd_valid, 1'b0);
        check({tag, "_rdd"}, rd_data, 16'd0);
        check({tag, "_p1b"}, ch1_peak_bin, 13'd0);
        check({tag, "_p1m"}, ch1_peak_mag, 16'd0);
        check({tag, "_p2b"}, ch2_peak_bin, 13'd0);
        check({tag, "_p2m"}, ch2_peak_mag, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        ch1_wr_data = '0; ch1_wr_addr = '0; ch1_wr_valid = 1'b0;
        ch2_wr_data = '0; ch2_wr_addr = '0; ch2_wr_valid = 1'b0;
        rd_lock = 2'b00; rd_en = 1'b0; rd_ch = 1'b0; rd_addr = '0;
        tick(2);
        check_zero("reset");
        rst = 1'b0;
        tick(1);

        // 1: plain frame, swap, read back
        run_frame(2'b01, 0, 8191, 0, 16'd0);
        tick(2);
        check("t1_fr0", fr0, 1);
        check("t1_fr1", fr1, 0);
        do_read(1'b0, 100, 16'd100, "t1_rd100");
        do_read(1'b0, 4095, 16'd4095, "t1_rd4095");

        // 2: locked frame stays hidden until unlock
        rd_lock = 2'b01;
        run_frame(2'b01, 0, 8191, 1, 16'hAAAA);
        tick(2);
        check("t2_fr_locked", fr0, 1);
        do_read(1'b0, 100, 16'd100, "t2_rd_old");
        rd_lock = 2'b00;
        tick(3);
        check("t2_fr_unlock", fr0, 2);
        do_read(1'b0, 100, 16'hAAAA, "t2_rd_new");

        // 3: two frames while locked, latest wins
        rd_lock = 2'b01;
        run_frame(2'b01, 0, 8191, 1, 16'h1111);
        run_frame(2'b01, 0, 8191, 1, 16'h2222);
        tick(2);
        check("t3_ovr", ovr_cnt, 16'd1);
        check("t3_fr_locked", fr0, 2);
        do_read(1'b0, 7, 16'hAAAA, "t3_rd_old");
        rd_lock = 2'b00;
        tick(3);
        check("t3_fr_unlock", fr0, 3);
        do_read(1'b0, 100, 16'h2222, "t3_rd_new");
        check("t3_ovr_hold", ovr_cnt, 16'd1);

        // 4: both channels together
        base0 = fr0;
        run_frame(2'b11, 0, 8191, 0, 16'd0);
        tick(2);
        check("t4_both", frb, 1);
        check("t4_fr0", fr0, base0 + 1);
        check("t4_fr1", fr1, 1);
        do_read(1'b0, 5, 16'd5, "t4_rd_c1");
        do_read(1'b1, 5, 16'hFFFA, "t4_rd_c2");
        do_read(1'b1, 4095, 16'hF000, "t4_rd_c2_top");
`ifdef SPEC_PEAK_DETECT_EN
        check("t4_p1b", ch1_peak_bin, 13'd4095);
        check("t4_p1m", ch1_peak_mag, 16'd4095);
        check("t4_p2b", ch2_peak_bin, 13'd4);
        check("t4_p2m", ch2_peak_mag, 16'hFFFB);
`else
        check("t4_p1b", ch1_peak_bin, 13'd0);
        check("t4_p2m", ch2_peak_mag, 16'd0);
`endif

        // 5: peak search ignores DC bins and keeps the lowest tie
        run_frame(2'b01, 0, 8191, 2, 16'd0);
        tick(2);
`ifdef SPEC_PEAK_DETECT_EN
        check("t5_p1b", ch1_peak_bin, 13'd700);
        check("t5_p1m", ch1_peak_mag, 16'd900);
`else
        check("t5_p1b", ch1_peak_bin, 13'd0);
        check("t5_p1m", ch1_peak_mag, 16'd0);
`endif
        do_read(1'b0, 3, 16'd5000, "t5_rd3");
        do_read(1'b0, 701, 16'd900, "t5_rd701");

        // 6: reset in the middle of a frame
        run_frame(2'b01, 0, 500, 1, 16'h5555);
        rst = 1'b1;
        tick(1);
        check_zero("t6_rst");
        rst = 1'b0;
        base0 = fr0;
        run_frame(2'b01, 0, 8191, 1, 16'd7);
        tick(2);
        check("t6_fr0", fr0, base0 + 1);
        do_read(1'b0, 100, 16'd7, "t6_rd100");
        do_read(1'b0, 0, 16'd7, "t6_rd0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
